wb_stage: RTL

//  Write-back stage of the 5-stage core: accepts one retiring instruction per cycle from MEM,

---
 rtl/wb_stage_pkg.sv | 13 +
 rtl/wb_stage_load_align.sv | 39 +++
 rtl/wb_stage.sv | 131 +++++++++++++
 3 files changed

// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back stage: bus width defaults and load op codes.
package wb_stage_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 5;

    localparam logic [2:0] MEM_OP_LB  = 3'b000;
    localparam logic [2:0] MEM_OP_LH  = 3'b001;
    localparam logic [2:0] MEM_OP_LW  = 3'b010;
    localparam logic [2:0] MEM_OP_LBU = 3'b100;
    localparam logic [2:0] MEM_OP_LHU = 3'b101;

endpackage

// File: rtl/wb_stage_load_align.sv
// Load data aligner: picks the addressed byte/half out of the little-endian RAM word
// and sign- or zero-extends it. Misaligned halves cannot reach here, so addr_lo[0]
// is ignored for halfword loads. Unknown op codes pass the full word through.
module wb_stage_load_align
    import wb_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [2:0]        op,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Lane select and extension of the returned word.
    always_comb begin
        byte_v = rdata[7:0];
        case (addr_lo)
            2'd0:    byte_v = rdata[7:0];
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            default: byte_v = rdata[31:24];
        endcase
        half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        data = rdata;
        case (op)
            MEM_OP_LB:  data = {{(DATA_W-8){byte_v[7]}}, byte_v};
            MEM_OP_LH:  data = {{(DATA_W-16){half_v[15]}}, half_v};
            MEM_OP_LBU: data = {{(DATA_W-8){1'b0}}, byte_v};
            MEM_OP_LHU: data = {{(DATA_W-16){1'b0}}, half_v};
            default:    data = rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: takes one retiring instruction per cycle from MEM, waits for the
// RAM response on loads, and drives the register-file write channel and retire trace.
//
//  state        | meaning
//  -------------+------------------------------------------------------------
//  ST_EMPTY     | nothing held; ready for a new instruction
//  ST_WAIT_LOAD | load captured, waiting for ram_rvalid
//  ST_VALID     | result complete; write/retire presented this cycle
//  ST_DRAIN     | load was flushed; swallow its RAM response, then go empty
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_pc,
    input  logic                  in_reg_wen,
    input  logic [REG_ADDR_W-1:0] in_reg_waddr,
    input  logic [DATA_W-1:0]     in_result,
    input  logic                  in_mem_read,
    input  logic [2:0]            in_mem_op,
    input  logic [1:0]            in_addr_lo,
    input  logic                  flush,
    input  logic                  ram_rvalid,
    input  logic [DATA_W-1:0]     ram_rdata,
    output logic                  write_en,
    output logic [REG_ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0]     write_data,
    output logic                  retire_valid,
    output logic [DATA_W-1:0]     retire_pc
);

    typedef enum logic [1:0] {
        ST_EMPTY     = 2'd0,
        ST_WAIT_LOAD = 2'd1,
        ST_VALID     = 2'd2,
        ST_DRAIN     = 2'd3
    } state_t;

    state_t                state_q;
    logic [DATA_W-1:0]     pc_q;
    logic                  wen_q;
    logic [REG_ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0]     data_q;
    logic [2:0]            op_q;
    logic [1:0]            addr_lo_q;

    logic                  accept;
    logic                  is_valid;
    logic [DATA_W-1:0]     aligned_data;

    wb_stage_load_align #(.DATA_W(DATA_W)) u_load_align (
        .op      (op_q),
        .addr_lo (addr_lo_q),
        .rdata   (ram_rdata),
        .data    (aligned_data)
    );

    // Handshake: only EMPTY/VALID can take a new instruction, and never during flush.
    always_comb begin
        in_ready = ((state_q == ST_EMPTY) || (state_q == ST_VALID)) && !flush;
        accept   = in_valid && in_ready;
    end

    // Stage FSM and holding registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_EMPTY;
            pc_q      <= '0;
            wen_q     <= 1'b0;
            waddr_q   <= '0;
            data_q    <= '0;
            op_q      <= '0;
            addr_lo_q <= '0;
        end else begin
            case (state_q)
                ST_EMPTY, ST_VALID: begin
                    if (accept) begin
                        pc_q      <= in_pc;
                        wen_q     <= in_reg_wen;
                        waddr_q   <= in_reg_waddr;
                        op_q      <= in_mem_op;
                        addr_lo_q <= in_addr_lo;
                        if (in_mem_read) begin
                            data_q  <= '0;
                            state_q <= ST_WAIT_LOAD;
                        end else begin
                            data_q  <= in_result;
                            state_q <= ST_VALID;
                        end
                    end else begin
                        state_q <= ST_EMPTY;
                    end
                end
                ST_WAIT_LOAD: begin
                    if (ram_rvalid) begin
                        if (flush) begin
                            state_q <= ST_EMPTY;
                        end else begin
                            data_q  <= aligned_data;
                            state_q <= ST_VALID;
                        end
                    end else if (flush) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (ram_rvalid) begin
                        state_q <= ST_EMPTY;
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

    // Write channel and retire trace; r0 writes are suppressed so forwarding stays zero.
    always_comb begin
        is_valid     = (state_q == ST_VALID);
        write_en     = is_valid && wen_q && (waddr_q != '0);
        write_addr   = is_valid ? waddr_q : '0;
        write_data   = is_valid ? data_q : '0;
        retire_valid = is_valid;
        retire_pc    = is_valid ? pc_q : '0;
    end

endmodule
